// File: rtl/hazard_scoreboard_if.sv
// Decode/Execute hazard bundle: instruction tags and branch/cond inputs toward the scoreboard, forward selects and stall/flush back.
// Purely structural; no timing or backpressure of its own.
interface hazard_scoreboard_if #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2
);
  localparam int FS_W = $clog2(NUM_FWD + 1);

  logic                      valid_d;
  logic [NUM_SRC*REG_AW-1:0] src_d;
  logic [REG_AW-1:0]         dst_d;
  logic                      we_d;
  logic                      load_d;
  logic                      cond_fail_e;
  logic                      branch_taken_e;
  logic [NUM_SRC*FS_W-1:0]   fwd_sel_e;
  logic                      stall_f;
  logic                      stall_d;
  logic                      flush_d;
  logic                      flush_e;

  modport master (
    output valid_d, src_d, dst_d, we_d, load_d, cond_fail_e, branch_taken_e,
    input  fwd_sel_e, stall_f, stall_d, flush_d, flush_e
  );

  modport slave (
    input  valid_d, src_d, dst_d, we_d, load_d, cond_fail_e, branch_taken_e,
    output fwd_sel_e, stall_f, stall_d, flush_d, flush_e
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination tags from Execute onward; drives forward selects and stall/flush (HAZ_PERF_CNT_EN adds stall/flush counters).
// Outputs are combinational from tracked state and Decode inputs; Execute and later stages never stall, so there is no backpressure.
module hazard_scoreboard #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int FWD_LD  = 2
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  localparam int                FS_W    = $clog2(NUM_FWD + 1);
  localparam logic [REG_AW-1:0] PC_ADDR = '1;

  logic [NUM_FWD:0]  valid_q;
  logic [NUM_FWD:0]  we_q;
  logic [NUM_FWD:0]  load_q;
  logic [REG_AW-1:0] dst_q   [NUM_FWD+1];
  logic [REG_AW-1:0] src_e_q [NUM_SRC];

  logic lu;
  logic stall_int;
  logic flush_e_int;

  // Control bits of the tracking pipe; index 0 is Execute.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      we_q    <= '0;
      load_q  <= '0;
    end else begin
      valid_q[0] <= hz.valid_d & ~flush_e_int;
      we_q[0]    <= hz.valid_d & hz.we_d & ~flush_e_int;
      load_q[0]  <= hz.valid_d & hz.load_d & ~flush_e_int;
      for (int k = 1; k <= NUM_FWD; k++) begin
        valid_q[k] <= valid_q[k-1];
        load_q[k]  <= load_q[k-1];
        we_q[k]    <= (k == 1) ? (we_q[0] & ~hz.cond_fail_e) : we_q[k-1];
      end
    end
  end

  // Tags are only meaningful alongside valid/we, so they carry no reset.
  always_ff @(posedge clk) begin
    dst_q[0] <= hz.dst_d;
    for (int k = 1; k <= NUM_FWD; k++) begin
      dst_q[k] <= dst_q[k-1];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      src_e_q[i] <= hz.src_d[i*REG_AW +: REG_AW];
    end
  end

  // Load-use: a load younger than FWD_LD cannot supply Decode in time.
  always_comb begin
    lu = 1'b0;
    for (int k = 0; k < FWD_LD - 1; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (valid_q[k] && load_q[k] && we_q[k] &&
            hz.src_d[i*REG_AW +: REG_AW] != PC_ADDR &&
            hz.src_d[i*REG_AW +: REG_AW] == dst_q[k]) begin
          lu = 1'b1;
        end
      end
    end
    lu = lu & hz.valid_d;
  end

  always_comb begin
    stall_int   = lu & ~hz.branch_taken_e;
    flush_e_int = lu | hz.branch_taken_e;
    hz.stall_f  = 1'b0;
    hz.stall_d  = 1'b0;
    hz.flush_d  = 1'b0;
    hz.flush_e  = 1'b0;
    if (!reset) begin
      hz.stall_f = stall_int;
      hz.stall_d = stall_int;
      hz.flush_d = hz.branch_taken_e;
      hz.flush_e = flush_e_int;
    end
  end

  // Scan oldest to youngest so the youngest eligible writer wins.
  always_comb begin : fwd_search
    logic [FS_W-1:0] sel;
    hz.fwd_sel_e = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel = '0;
      for (int k = NUM_FWD; k >= 1; k--) begin
        if (valid_q[k] && we_q[k] && dst_q[k] == src_e_q[i] &&
            !(load_q[k] && k < FWD_LD)) begin
          sel = FS_W'(k);
        end
      end
      if (reset || src_e_q[i] == PC_ADDR) begin
        sel = '0;
      end
      hz.fwd_sel_e[i*FS_W +: FS_W] = sel;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_int && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (hz.branch_taken_e && flush_cnt_q != 32'hFFFF_FFFF) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = reset ? 32'd0 : stall_cnt_q;
  assign flush_cnt = reset ? 32'd0 : flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: default config (A) and NUM_FWD=3/FWD_LD=3/NUM_SRC=3 (B) share stimulus; a queue-fed monitor checks both.
// Expected values come from an in-bench model of in-flight instructions.
module tb_hazard_scoreboard;

  localparam int PC = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(4), .NUM_SRC(2), .NUM_FWD(2)) hz_a ();
  hazard_scoreboard_if #(.REG_AW(4), .NUM_SRC(3), .NUM_FWD(3)) hz_b ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

  hazard_scoreboard #(.REG_AW(4), .NUM_SRC(2), .NUM_FWD(2), .FWD_LD(2)) dut_a (
    .clk(clk), .reset(reset), .hz(hz_a)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
`endif
  );

  hazard_scoreboard #(.REG_AW(4), .NUM_SRC(3), .NUM_FWD(3), .FWD_LD(3)) dut_b (
    .clk(clk), .reset(reset), .hz(hz_b)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
`endif
  );

  // Model configuration per DUT: forwarding depth, first load-forwarding stage, operand count.
  int NF [2] = '{2, 3};
  int FL [2] = '{2, 3};
  int NS [2] = '{2, 3};

  // In-flight instructions; index 0 is Execute, larger index is older.
  bit m_valid [2][4];
  bit m_we    [2][4];
  bit m_load  [2][4];
  int m_dst   [2][4];
  int m_src   [2][3];
  int unsigned m_scnt [2];
  int unsigned m_fcnt [2];
  bit last_stall [2];

  typedef struct packed {
    logic        chk_a;
    logic        chk_b;
    logic [5:0]  fwd_a;
    logic [5:0]  fwd_b;
    logic [3:0]  ctl_a;
    logic [3:0]  ctl_b;
    logic [31:0] scnt_a;
    logic [31:0] fcnt_a;
    logic [31:0] scnt_b;
    logic [31:0] fcnt_b;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;

  // Forward source: the youngest post-Execute writer of the register whose data exists by then.
  function automatic int m_fwd(int c, int i);
    if (m_src[c][i] == PC) return 0;
    for (int k = 1; k <= NF[c]; k++) begin
      if (m_valid[c][k] && m_we[c][k] && m_dst[c][k] == m_src[c][i]) begin
        if (!(m_load[c][k] && k < FL[c])) return k;
      end
    end
    return 0;
  endfunction

  // Stall when a load that will still be too young once Decode reaches Execute feeds Decode.
  function automatic bit m_lu(int c, bit vd, int s0, int s1, int s2);
    int s [3];
    s = '{s0, s1, s2};
    if (!vd) return 1'b0;
    for (int k = 0; k <= FL[c] - 2; k++) begin
      if (m_valid[c][k] && m_load[c][k] && m_we[c][k]) begin
        for (int i = 0; i < NS[c]; i++) begin
          if (s[i] != PC && s[i] == m_dst[c][k]) return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(bit rst, bit vd, int s0, int s1, int s2, int dst,
                     bit we, bit ld, bit cf, bit br);
    exp_t        e;
    logic [5:0]  fw [2];
    logic [3:0]  ct [2];
    bit          ck [2];
    logic [31:0] sc [2];
    logic [31:0] fc [2];
    bit          lu, stl, fle;
    @(posedge clk);
    #1;
    reset                 = rst;
    hz_a.valid_d          = vd;
    hz_b.valid_d          = vd;
    hz_a.src_d            = {4'(s1), 4'(s0)};
    hz_b.src_d            = {4'(s2), 4'(s1), 4'(s0)};
    hz_a.dst_d            = 4'(dst);
    hz_b.dst_d            = 4'(dst);
    hz_a.we_d             = we;
    hz_b.we_d             = we;
    hz_a.load_d           = ld;
    hz_b.load_d           = ld;
    hz_a.cond_fail_e      = cf;
    hz_b.cond_fail_e      = cf;
    hz_a.branch_taken_e   = br;
    hz_b.branch_taken_e   = br;
    for (int c = 0; c < 2; c++) begin
      lu  = m_lu(c, vd, s0, s1, s2);
      stl = lu && !br;
      fle = lu || br;
      fw[c] = '0;
      for (int i = 0; i < NS[c]; i++) fw[c][i*2 +: 2] = rst ? 2'd0 : 2'(m_fwd(c, i));
      ct[c] = rst ? 4'd0 : {stl, stl, br, fle};
      ck[c] = rst || m_valid[c][0];
      sc[c] = rst ? 32'd0 : m_scnt[c];
      fc[c] = rst ? 32'd0 : m_fcnt[c];
      last_stall[c] = !rst && stl;
      if (rst) begin
        for (int k = 0; k < 4; k++) begin
          m_valid[c][k] = 0;
          m_we[c][k]    = 0;
          m_load[c][k]  = 0;
        end
        m_scnt[c] = 0;
        m_fcnt[c] = 0;
      end else begin
        if (stl && m_scnt[c] != 32'hFFFF_FFFF) m_scnt[c]++;
        if (br && m_fcnt[c] != 32'hFFFF_FFFF) m_fcnt[c]++;
        for (int k = NF[c]; k >= 1; k--) begin
          m_valid[c][k] = m_valid[c][k-1];
          m_load[c][k]  = m_load[c][k-1];
          m_dst[c][k]   = m_dst[c][k-1];
          m_we[c][k]    = (k == 1) ? (m_we[c][0] && !cf) : m_we[c][k-1];
        end
        m_valid[c][0] = vd && !fle;
        m_we[c][0]    = vd && we && !fle;
        m_load[c][0]  = vd && ld && !fle;
        m_dst[c][0]   = dst;
        m_src[c][0]   = s0;
        m_src[c][1]   = s1;
        m_src[c][2]   = s2;
      end
    end
    e        = '0;
    e.chk_a  = ck[0];
    e.chk_b  = ck[1];
    e.fwd_a  = fw[0];
    e.fwd_b  = fw[1];
    e.ctl_a  = ct[0];
    e.ctl_b  = ct[1];
    e.scnt_a = sc[0];
    e.fcnt_a = fc[0];
    e.scnt_b = sc[1];
    e.fcnt_b = fc[1];
    exp_q.push_back(e);
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Keeps an instruction in Decode while config hold_c stalls it, as the real Fetch/Decode would.
  task automatic issue(int hold_c, int s0, int s1, int s2, int dst, bit we, bit ld);
    int n = 0;
    do begin
      cyc(0, 1, s0, s1, s2, dst, we, ld, 0, 0);
      n++;
    end while (last_stall[hold_c] && n < 6);
  endtask

  function automatic int rreg();
    return ($urandom_range(0, 9) == 0) ? PC : int'($urandom_range(0, 4));
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("ctl_a", 32'({hz_a.stall_f, hz_a.stall_d, hz_a.flush_d, hz_a.flush_e}), 32'(mon_e.ctl_a));
      check("ctl_b", 32'({hz_b.stall_f, hz_b.stall_d, hz_b.flush_d, hz_b.flush_e}), 32'(mon_e.ctl_b));
      if (mon_e.chk_a) check("fwd_a", 32'(hz_a.fwd_sel_e), 32'(mon_e.fwd_a[3:0]));
      if (mon_e.chk_b) check("fwd_b", 32'(hz_b.fwd_sel_e), 32'(mon_e.fwd_b));
`ifdef HAZ_PERF_CNT_EN
      check("stall_cnt_a", stall_cnt_a, mon_e.scnt_a);
      check("flush_cnt_a", flush_cnt_a, mon_e.fcnt_a);
      check("stall_cnt_b", stall_cnt_b, mon_e.scnt_b);
      check("flush_cnt_b", flush_cnt_b, mon_e.fcnt_b);
`endif
    end
  end

  initial begin
    reset = 1'b1;
    hz_a.valid_d = 0; hz_a.src_d = '0; hz_a.dst_d = '0; hz_a.we_d = 0; hz_a.load_d = 0;
    hz_a.cond_fail_e = 0; hz_a.branch_taken_e = 0;
    hz_b.valid_d = 0; hz_b.src_d = '0; hz_b.dst_d = '0; hz_b.we_d = 0; hz_b.load_d = 0;
    hz_b.cond_fail_e = 0; hz_b.branch_taken_e = 0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 3, 3, 3, 1, 1, 0, 1);
    idle(2);

    // ADD r3; SUB r3,r1 forwards from M; a third reader forwards from W.
    issue(0, 1, 2, 0, 3, 1, 0);
    issue(0, 3, 1, 0, 7, 1, 0);
    issue(0, 3, 3, 3, 8, 1, 0);
    idle(4);

    // LDR r2 then a consumer: single stall on A, forward from W.
    issue(0, 0, 0, 0, 2, 1, 1);
    issue(0, 2, 1, 0, 9, 1, 0);
    idle(4);

    // Load-use coinciding with a taken branch: branch wins.
    issue(0, 0, 0, 0, 2, 1, 1);
    cyc(0, 1, 2, 1, 0, 9, 1, 0, 0, 1);
    idle(4);

    // Condition-failed producer of r4 does not forward.
    issue(0, 0, 0, 0, 4, 1, 0);
    cyc(0, 1, 4, 4, 4, 9, 1, 0, 1, 0);
    idle(4);

    // PC as source never hazards, even against a load or writer of r15.
    issue(0, 0, 0, 0, 15, 1, 1);
    issue(0, 15, 15, 15, 15, 1, 0);
    issue(0, 15, 0, 15, 1, 1, 0);
    idle(4);

    // Config B: load r5 then immediate consumer: two stalls, forward from stage 3.
    issue(1, 0, 0, 0, 5, 1, 1);
    issue(1, 5, 0, 1, 9, 1, 0);
    idle(5);

    // Two writers of r6: the younger one wins.
    issue(1, 0, 0, 0, 6, 1, 0);
    issue(1, 0, 0, 0, 6, 1, 0);
    issue(1, 6, 6, 6, 9, 1, 0);
    idle(5);

    // Reset with in-flight writers; nothing survives it.
    issue(1, 0, 0, 0, 9, 1, 0);
    issue(1, 0, 0, 0, 10, 1, 1);
    issue(1, 0, 0, 0, 11, 1, 0);
    cyc(1, 1, 9, 10, 11, 12, 1, 0, 0, 0);
    cyc(1, 1, 9, 10, 11, 12, 1, 0, 0, 1);
    issue(1, 9, 10, 11, 12, 1, 0);
    idle(5);

    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 149) == 0),
          ($urandom_range(0, 7) != 0),
          rreg(), rreg(), rreg(), rreg(),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 7) == 0));
    end
    idle(2);

    @(posedge clk);
    @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed M/W match-signal hazard logic in the 5-stage ARM pipeline.
- Tracks destination tags of in-flight instructions from Execute through a configurable number of post-Execute stages.
- Produces per-operand forward selects for Execute, plus stall/flush controls for Fetch/Decode/Execute.
- Handles any source-operand count, register-address width, and load-result latency.

Parameters:
REG_AW, 4, register address width; address {REG_AW{1'b1}} is the PC and is never a hazard source
NUM_SRC, 2, number of source operands per instruction (3 for multiply-accumulate)
NUM_FWD, 2, post-Execute stages able to forward (1=M … NUM_FWD=W); must be ≥1
FWD_LD, 2, first stage index whose load data is forwardable (1≤FWD_LD≤NUM_FWD)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid_d  in  1  Decode holds a real instruction
src_d  in  NUM_SRC*REG_AW  Decode source register addresses, operand i at [i*REG_AW+:REG_AW]
dst_d  in  REG_AW  Decode destination register
we_d  in  1  Decode instruction writes dst_d
load_d  in  1  Decode instruction is a load
cond_fail_e  in  1  Execute instruction's condition failed; cancels its write
branch_taken_e  in  1  branch resolved taken in Execute
fwd_sel_e  out  NUM_SRC*FS_W  per-operand forward select, FS_W=$clog2(NUM_FWD+1); 0=register file, k=stage k
stall_f  out  1  hold PC
stall_d  out  1  hold Fetch→Decode register
flush_d  out  1  clear Fetch→Decode register
flush_e  out  1  clear Decode→Execute register

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Entry array, stages 0 (Execute) … NUM_FWD. Each entry holds valid, we, load, dst. Stage 0 also holds src tags.
- Every posedge, stage k+1 ← stage k for all k. There is no stall of Execute or later stages.
- Stage 1 receives we & ~cond_fail_e from stage 0.
- Stage 0 ← Decode inputs, or a bubble (valid=0, we=0, load=0) when flush_e=1.
- Reset: at the next edge all entries are cleared to valid=0, we=0, load=0. While reset=1, all outputs are forced to 0.
- Forwarding, combinational, zero latency:
  - For operand i, fwd_sel_e = smallest k in 1..NUM_FWD with valid_k & we_k & dst_k==src_e[i]; otherwise 0.
  - Any src equal to all-ones (PC) gives 0.
  - A load entry at stage k<FWD_LD is not eligible. The search continues to older stages; the stall below guarantees such a case never needs forwarding.
- Load-use stall, combinational:
  - lu = valid_d & ∃ stage k, 0≤k≤FWD_LD-2, with valid_k & load_k & we_k & dst_k == any non-PC src_d.
  - Stage 0 is checked ignoring cond_fail_e (conservative).
  - If lu & ~branch_taken_e: stall_f=1, stall_d=1, flush_e=1.
- Branch: branch_taken_e=1 → flush_d=1, flush_e=1, stall_f=0, stall_d=0. Branch wins over a simultaneous stall.
- Otherwise all stall/flush outputs are 0.
- Simultaneous flush_e and Decode inputs: Decode contents are discarded and a bubble enters stage 0.
- Decode with valid_d=0 never stalls and is loaded as a bubble.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0]:
  - Both cleared by reset.
  - stall_cnt increments each cycle stall_d=1.
  - flush_cnt increments each cycle branch_taken_e=1.
  - Both saturate at 32'hFFFFFFFF.
- When undefined, these ports and the counter logic do not exist. All other behaviour is identical.

Test Plan:
- Default params; ADD r3 (we_d=1, dst=3) then next cycle SUB src r3,r1 → fwd_sel operand0=1 (M), operand1=0. One cycle later, a third instruction reading r3 gets fwd_sel=2 (W).
- LDR r2 in Execute (load=1, dst=2); Decode reads r2 → stall_f=stall_d=flush_e=1 for exactly 1 cycle. Next cycle the consumer sees fwd_sel=2.
- Same load-use with branch_taken_e=1 in that cycle → flush_d=flush_e=1, stall_f=stall_d=0.
- Producer r4 in Execute with cond_fail_e=1, consumer reads r4 next cycle → fwd_sel=0. Source r15 matching a dst of 15 → fwd_sel=0, no stall.
- NUM_FWD=3, FWD_LD=3: load r5 then immediate consumer → 2 stall cycles, then fwd_sel=3. Two writers of r6 at stages 1 and 2 → fwd_sel=1 (youngest wins).
- Assert reset mid-stream with 3 valid entries → outputs 0 during reset. After release, a consumer of a previously pending dst sees fwd_sel=0; with HAZ_PERF_CNT_EN the counters read 0.
